pr_elastic: RTL and testbench

PR_ELASTIC -- requirements
Module: pr_elastic

---
 rtl/pr_elastic.sv | 157 +++++++++++++++
 tb/tb_pr_elastic.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pr_elastic.sv
// -----------------------------------------------------------------------------
// pr_elastic -- two-entry elastic pipeline register (main + skid)
//
// Decouples two pipeline stages with a valid/ready handshake. The main
// register always holds the oldest payload and drives OUT_DATA directly; the
// skid register catches one extra payload when downstream stalls. IN_READY and
// OUT_VALID are registered so neither handshake has a combinational path
// through this block.
//
// Parameters:
//   WIDTH        payload bits per entry (1..1024)
//
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-low reset
//   IN_VALID     upstream payload valid
//   IN_READY     block can accept a payload this cycle (flop output)
//   IN_DATA      upstream payload
//   FLUSH        synchronous kill of all held entries, priority over all else
//   OUT_VALID    OUT_DATA holds a valid payload (flop output)
//   OUT_READY    downstream consumes OUT_DATA this cycle
//   OUT_DATA     oldest held payload (main register)
//   OCCUPANCY    number of held entries, 0..2
//   STALL_COUNT  saturating count of edges with OUT_VALID=1 and OUT_READY=0
//                (present only when PR_ELASTIC_STALL_CNT_EN is defined)
//
// Configuration macro: PR_ELASTIC_STALL_CNT_EN
// -----------------------------------------------------------------------------
module pr_elastic #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       OCCUPANCY
`ifdef PR_ELASTIC_STALL_CNT_EN
  ,
  output logic [31:0]      STALL_COUNT
`endif
);

  // State encoding equals the number of held entries, so OCCUPANCY is the
  // state register itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_drain;

  assign w_accept = IN_VALID & r_in_ready;
  assign w_drain  = r_out_valid & OUT_READY;

  // Next-state and datapath steering.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (FLUSH) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = IN_DATA;
          end
        end
        S_HALF: begin
          if (w_accept && !w_drain) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = IN_DATA;
          end else if (w_accept && w_drain) begin
            // Pass-through: the outgoing payload is replaced in one cycle.
            w_main_nxt  = IN_DATA;
          end else if (w_drain) begin
            // Main keeps its stale value; OUT_VALID=0 marks it unused.
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // IN_READY is low here, so no accept can occur.
          if (w_drain) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create ordering races.
  // NOTE: the payload registers are reset (not just the control flops)
  // because OUT_DATA must read 0 while in reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      // Handshake flags are registered copies of the next-state decode.
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_main;
  assign OCCUPANCY = r_state;

`ifdef PR_ELASTIC_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts back-pressure edges; FLUSH deliberately leaves it alone.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !OUT_READY && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign STALL_COUNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pr_elastic.sv
// -----------------------------------------------------------------------------
// tb_pr_elastic -- self-checking bench for pr_elastic
//
// A queue-based model (capacity two, oldest first) predicts the handshake
// flags, occupancy, head payload and stall count after every clock edge.
// Directed scenarios cover fill/stall, drain, streaming, flush and async
// reset; randomized traffic with occasional flushes and resets follows.
// Define PR_ELASTIC_STALL_CNT_EN to also exercise the stall counter.
// -----------------------------------------------------------------------------
module tb_pr_elastic;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PR_ELASTIC_STALL_CNT_EN
  logic [31:0]  stall_count;
`endif

  always #5 clk = ~clk;

  pr_elastic #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .FLUSH     (flush),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OCCUPANCY (occupancy)
`ifdef PR_ELASTIC_STALL_CNT_EN
    ,
    .STALL_COUNT (stall_count)
`endif
  );

  // Reference model: held payloads in acceptance order plus stall counter.
  logic [W-1:0] m_q[$];
  logic [31:0]  m_stall;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
    check({tag, "/in_ready"},  64'(in_ready),  64'(m_q.size() != 2));
    check({tag, "/occupancy"}, 64'(occupancy), 64'(m_q.size()));
    if (m_q.size() != 0) check({tag, "/out_data"}, out_data, m_q[0]);
`ifdef PR_ELASTIC_STALL_CNT_EN
    check({tag, "/stall_count"}, 64'(stall_count), 64'(m_stall));
`endif
  endtask

  // Drive one cycle's inputs, advance one edge, update model, check at negedge.
  task automatic step(input string tag, input logic iv, input logic [W-1:0] id,
                      input logic fl, input logic ordy);
    logic acc;
    logic drn;
    in_valid  = iv;
    in_data   = id;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    acc = iv && (m_q.size() < 2);
    drn = (m_q.size() > 0) && ordy;
    if ((m_q.size() > 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (fl) begin
      m_q.delete();
    end else begin
      if (drn) void'(m_q.pop_front());
      if (acc) m_q.push_back(id);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Assert reset between edges and check its effect before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b1;     // must not be accepted while reset is low
    in_data  = 64'hDEAD;
    #1;
    m_q.delete();
    m_stall = '0;
    check({tag, "/rst_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/rst_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "/rst_occupancy"}, 64'(occupancy), 64'd0);
    check({tag, "/rst_out_data"},  out_data,       64'd0);
`ifdef PR_ELASTIC_STALL_CNT_EN
    check({tag, "/rst_stall"},     64'(stall_count), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    check_outputs({tag, "/post_rst"});
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_stall   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset/out_data", out_data, 64'd0);
    check_outputs("reset");
    reset = 1'b1;

    // Fill with downstream stalled: A accepted, B accepted, C refused
    step("fill_a", 1'b1, 64'h1, 1'b0, 1'b0);
    check("fill_a/occ", 64'(occupancy), 64'd1);
    step("fill_b", 1'b1, 64'h2, 1'b0, 1'b0);
    check("fill_b/occ", 64'(occupancy), 64'd2);
    check("fill_b/in_ready", 64'(in_ready), 64'd0);
    step("fill_c", 1'b1, 64'h3, 1'b0, 1'b0);
    check("fill_c/occ", 64'(occupancy), 64'd2);
    check("fill_c/out_data", out_data, 64'h1);

    // Drain both in order
    step("drain_1", 1'b0, 64'h0, 1'b0, 1'b1);
    check("drain_1/out_data", out_data, 64'h2);
    step("drain_2", 1'b0, 64'h0, 1'b0, 1'b1);
    check("drain_2/out_valid", 64'(out_valid), 64'd0);
    check("drain_2/occ", 64'(occupancy), 64'd0);

    // Streaming: one transfer per cycle, IN_READY stays high
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b1, 64'(100 + i), 1'b0, 1'b1);
      check("stream/in_ready", 64'(in_ready), 64'd1);
      check("stream/out_data", out_data, 64'(100 + i));
    end
    step("stream_end", 1'b0, 64'h0, 1'b0, 1'b1);

    // Flush from FULL with simultaneous accept and drain
    step("fl_a", 1'b1, 64'hA, 1'b0, 1'b0);
    step("fl_b", 1'b1, 64'hB, 1'b0, 1'b0);
    step("flush", 1'b1, 64'hC, 1'b1, 1'b1);
    check("flush/out_valid", 64'(out_valid), 64'd0);
    check("flush/out_data",  out_data,       64'd0);
    check("flush/in_ready",  64'(in_ready),  64'd1);
    step("post_flush", 1'b0, 64'h0, 1'b0, 1'b0);

    // Async reset while FULL
    step("r_a", 1'b1, 64'h11, 1'b0, 1'b0);
    step("r_b", 1'b1, 64'h22, 1'b0, 1'b0);
    async_reset("mid_reset");

`ifdef PR_ELASTIC_STALL_CNT_EN
    // Five stalled edges, then a flush that does not clear the count
    step("st_load", 1'b1, 64'h5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("st_hold", 1'b0, 64'h0, 1'b0, 1'b0);
    check("st_hold/count", 64'(stall_count), 64'd5);
    step("st_flush", 1'b0, 64'h0, 1'b1, 1'b1);
    check("st_flush/count", 64'(stall_count), 64'd5);
    step("st_after", 1'b0, 64'h0, 1'b0, 1'b0);
    check("st_after/count", 64'(stall_count), 64'd5);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_reset");
      end else begin
        step("rand",
             1'($urandom_range(0, 3) != 0),
             {$urandom, $urandom},
             1'($urandom_range(0, 31) == 0),
             1'($urandom_range(0, 2) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
